pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit for the multi-cycle RV32I core.
- Holds the architectural PC and the previous PC (pc_old), which the datapath needs for branch/JAL offset math.
- Registers the branch/jump decision when the control FSM strobes it, and applies it only on an explicit update strobe.
- Adds signed-correct compares, JALR LSB clearing, misaligned-target trapping and a trap-recovery path.

Parameters:
- XLEN, 32, datapath/PC width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap_clear.
- IALIGN, 32, instruction alignment in bits. 32 traps targets with bit1 set. 16 disables the bit1 check.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- branch_eval  in  1  strobe from control FSM: evaluate and latch the taken decision
- pc_update  in  1  strobe from control FSM: advance PC this cycle
- trap_clear  in  1  leave TRAP state and redirect to TRAP_VECTOR
- opcode  in  7  current instruction opcode
- func3  in  3  current instruction func3
- rs1v  in  XLEN  rs1 value
- rs2v  in  XLEN  rs2 value
- target  in  XLEN  ALU-computed jump/branch target
- pc  out  XLEN  current PC
- pc_old  out  XLEN  PC before the most recent successful update
- pc_plus4  out  XLEN  combinational pc + 4 (link value), wraps mod 2^XLEN
- taken  out  1  registered decision awaiting pc_update
- misaligned  out  1  sticky trap flag
- halted  out  1  high while in TRAP state

Behaviour:
- Reset: rst_n low at a rising edge sets
  - pc = pc_old = RESET_VECTOR
  - taken = 0, misaligned = 0, state = RUN, halted = 0
  - Reset overrides every other input in that cycle, including mid-trap.
- Decision function, combinational, latched into taken on a branch_eval edge (visible next cycle):
  - opcode 1100011, func3 000: rs1v == rs2v
  - func3 001: !=
  - func3 100: signed <
  - func3 101: signed >=
  - func3 110: unsigned <
  - func3 111: unsigned >=
  - func3 010 or 011: 0
  - opcode 1101111 (JAL): 1
  - opcode 1100111 (JALR): 1
  - Any other opcode: 0
- Next-PC computation:
  - next = taken ? tgt : pc + 4
  - tgt = target with bit0 forced to 0 when opcode is JALR; otherwise tgt = target.
  - Sequential increment wraps: pc 32'hFFFF_FFFC -> 32'h0000_0000.
- pc_update edge in RUN:
  - If taken and IALIGN == 32 and tgt[1] == 1: misaligned <= 1, state <= TRAP, pc and pc_old unchanged, taken <= 0.
  - Otherwise: pc_old <= pc, pc <= next, taken <= 0.
- Simultaneous branch_eval and pc_update:
  - pc_update consumes the taken value registered before this edge.
  - taken then loads the new decision (eval wins over clear).
- States:
  - RUN: normal operation.
  - TRAP: halted = 1. pc_update and branch_eval are ignored, taken is held at 0.
  - TRAP, trap_clear at an edge: pc_old <= pc, pc <= TRAP_VECTOR, misaligned <= 0, state <= RUN.
  - trap_clear in RUN is ignored.
- Latency: decision to pc_update takes at least 1 cycle (taken is registered); the PC change is visible the cycle after the pc_update edge.
- pc is never written to an unaligned value when IALIGN = 32.

Decomposition:
- Shared package core_pkg holds:
  - Opcode constants: OP_BRANCH, OP_JAL, OP_JALR.
  - func3 constants: F3_BEQ .. F3_BGEU.
  - Enum pc_state_t {PC_RUN, PC_TRAP}.
- One sub-module, branch_cmp: purely combinational (opcode, func3, rs1v, rs2v) -> take. Reused by the verification scoreboard model.

Test Plan:
- Reset then 3 pc_update strobes, no branch_eval -> pc 0x0, 0x4, 0x8, 0xC; pc_old trails by one step.
- opcode 1100011, func3 100, rs1v = 0xFFFF_FFFF, rs2v = 0x1, branch_eval, then target = 0x40 with pc_update -> taken = 1, pc = 0x40. Repeat with func3 110 -> taken = 0, pc = pc + 4.
- JALR with target = 0x0000_0123 (bit1 = 1, bit0 = 1): eval then update -> misaligned = 1, halted = 1, pc unchanged. Further pc_update pulses leave pc unchanged. trap_clear -> pc = 0x100, misaligned = 0.
- JALR with target = 0x0000_0081: eval then update -> pc = 0x80, no trap. Same target with IALIGN = 16 and target 0x82 -> pc = 0x82.
- pc = 0xFFFF_FFFC, pc_update with taken = 0 -> pc = 0x0. branch_eval and pc_update in the same cycle with an older taken = 0 and a new BEQ-equal decision -> pc = pc + 4, and taken = 1 afterwards.
- rst_n low during TRAP, asserted together with trap_clear -> pc = RESET_VECTOR, state RUN, all flags 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I control constants and the PC-unit state type.
package core_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [0:0] {
        PC_RUN  = 1'b0,
        PC_TRAP = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_unit_if.sv
// Control/datapath bundle between the multi-cycle control FSM and the PC unit.
interface pc_unit_if #(
    parameter int XLEN = 32
);
    logic            branch_eval;
    logic            pc_update;
    logic            trap_clear;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [XLEN-1:0] rs1v;
    logic [XLEN-1:0] rs2v;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_old;
    logic [XLEN-1:0] pc_plus4;
    logic            taken;
    logic            misaligned;
    logic            halted;

    modport master (
        output branch_eval, pc_update, trap_clear, opcode, func3, rs1v, rs2v, target,
        input  pc, pc_old, pc_plus4, taken, misaligned, halted
    );

    modport slave (
        input  branch_eval, pc_update, trap_clear, opcode, func3, rs1v, rs2v, target,
        output pc, pc_old, pc_plus4, taken, misaligned, halted
    );
endinterface

// File: rtl/branch_cmp.sv
// Combinational taken/not-taken decision for RV32I branches and jumps.
module branch_cmp
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [6:0]      opcode,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1v,
    input  logic [XLEN-1:0] rs2v,
    output logic            take
);

    always_comb begin
        take = 1'b0;
        case (opcode)
            OP_BRANCH: begin
                case (func3)
                    F3_BEQ:  take = (rs1v == rs2v);
                    F3_BNE:  take = (rs1v != rs2v);
                    F3_BLT:  take = ($signed(rs1v) <  $signed(rs2v));
                    F3_BGE:  take = ($signed(rs1v) >= $signed(rs2v));
                    F3_BLTU: take = (rs1v <  rs2v);
                    F3_BGEU: take = (rs1v >= rs2v);
                    default: take = 1'b0;
                endcase
            end
            OP_JAL, OP_JALR: take = 1'b1;
            default:         take = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with registered branch decision, misaligned-target trap
// and trap-recovery redirect.
module pc_unit
    import core_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              IALIGN       = 32
) (
    input logic      clk,
    input logic      rst_n,
    pc_unit_if.slave bus
);

    localparam logic CHECK_BIT1 = (IALIGN == 32);

    pc_state_t       state_reg;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_old_reg;
    logic            taken_reg;
    logic            misaligned_reg;

    logic            decision;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_next;
    logic            align_fault;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .opcode (bus.opcode),
        .func3  (bus.func3),
        .rs1v   (bus.rs1v),
        .rs2v   (bus.rs2v),
        .take   (decision)
    );

    // JALR clears the target LSB before it is used or alignment-checked.
    always_comb begin
        tgt = bus.target;
        if (bus.opcode == OP_JALR) begin
            tgt[0] = 1'b0;
        end
    end

    assign pc_plus4    = pc_reg + XLEN'(4);
    assign pc_next     = taken_reg ? tgt : pc_plus4;
    assign align_fault = taken_reg && CHECK_BIT1 && tgt[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= PC_RUN;
            pc_reg         <= RESET_VECTOR;
            pc_old_reg     <= RESET_VECTOR;
            taken_reg      <= 1'b0;
            misaligned_reg <= 1'b0;
        end else begin
            case (state_reg)
                PC_RUN: begin
                    // A fresh evaluation overrides the clear caused by pc_update.
                    if (bus.branch_eval) begin
                        taken_reg <= decision;
                    end else if (bus.pc_update) begin
                        taken_reg <= 1'b0;
                    end
                    if (bus.pc_update) begin
                        if (align_fault) begin
                            misaligned_reg <= 1'b1;
                            state_reg      <= PC_TRAP;
                            taken_reg      <= 1'b0;
                        end else begin
                            pc_old_reg <= pc_reg;
                            pc_reg     <= pc_next;
                        end
                    end
                end
                PC_TRAP: begin
                    taken_reg <= 1'b0;
                    if (bus.trap_clear) begin
                        pc_old_reg     <= pc_reg;
                        pc_reg         <= TRAP_VECTOR;
                        misaligned_reg <= 1'b0;
                        state_reg      <= PC_RUN;
                    end
                end
                default: state_reg <= PC_RUN;
            endcase
        end
    end

    assign bus.pc         = pc_reg;
    assign bus.pc_old     = pc_old_reg;
    assign bus.pc_plus4   = pc_plus4;
    assign bus.taken      = taken_reg;
    assign bus.misaligned = misaligned_reg;
    assign bus.halted     = (state_reg == PC_TRAP);

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (IALIGN=32 main DUT, IALIGN=16 side DUT).
module tb_pc_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pc_unit_if #(.XLEN(32)) bus   ();
    pc_unit_if #(.XLEN(32)) bus16 ();

    pc_unit #(
        .XLEN(32), .RESET_VECTOR(32'h0000_0000), .TRAP_VECTOR(32'h0000_0100), .IALIGN(32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    pc_unit #(
        .XLEN(32), .RESET_VECTOR(32'h0000_0000), .TRAP_VECTOR(32'h0000_0100), .IALIGN(16)
    ) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.branch_eval = 1'b0;
        bus.pc_update   = 1'b0;
        bus.trap_clear  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++;
        if (bus.pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h0); end
        checks++;
        if (bus.pc_old !== 32'h0) begin errors++; $display("FAIL reset_pc_old: got %h want %h", bus.pc_old, 32'h0); end
        checks++;
        if (bus.pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4: got %h want %h", bus.pc_plus4, 32'h4); end
        checks++;
        if ({bus.taken, bus.misaligned, bus.halted} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {bus.taken, bus.misaligned, bus.halted});
        end
        $display("reset: pc=%h pc_old=%h", bus.pc, bus.pc_old);
    endtask

    task automatic test_sequential;
        logic [31:0] exp_pc;
        logic [31:0] exp_old;
        bus.opcode = 7'b0010011;
        exp_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            exp_old = exp_pc;
            exp_pc  = exp_pc + 32'h4;
            bus.pc_update = 1'b1;
            tick();
            idle();
            checks++;
            if (bus.pc !== exp_pc || bus.pc_old !== exp_old) begin
                errors++; $display("FAIL seq_step%0d: got pc=%h old=%h want pc=%h old=%h", i, bus.pc, bus.pc_old, exp_pc, exp_old);
            end
            $display("seq: pc=%h pc_old=%h", bus.pc, bus.pc_old);
        end
    endtask

    task automatic test_signed_branch;
        bus.opcode = 7'b1100011; bus.func3 = 3'b100;
        bus.rs1v = 32'hFFFF_FFFF; bus.rs2v = 32'h1; bus.target = 32'h40;
        bus.branch_eval = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.taken !== 1'b1) begin errors++; $display("FAIL blt_taken: got %b want 1", bus.taken); end
        bus.pc_update = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.pc !== 32'h40 || bus.pc_old !== 32'hC || bus.taken !== 1'b0) begin
            errors++; $display("FAIL blt_update: got pc=%h old=%h taken=%b want 40/c/0", bus.pc, bus.pc_old, bus.taken);
        end
        $display("blt: pc=%h pc_old=%h", bus.pc, bus.pc_old);
        bus.func3 = 3'b110; bus.target = 32'h80;
        bus.branch_eval = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.taken !== 1'b0) begin errors++; $display("FAIL bltu_taken: got %b want 0", bus.taken); end
        bus.pc_update = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.pc !== 32'h44 || bus.pc_old !== 32'h40) begin
            errors++; $display("FAIL bltu_update: got pc=%h old=%h want 44/40", bus.pc, bus.pc_old);
        end
        $display("bltu: pc=%h pc_old=%h", bus.pc, bus.pc_old);
    endtask

    task automatic test_decisions;
        // opcode, func3, rs1v, rs2v, expected taken
        logic [6:0]  op_t [7] = '{7'b1100011, 7'b1100011, 7'b1100011, 7'b1100011, 7'b1100011, 7'b0110011, 7'b1101111};
        logic [2:0]  f3_t [7] = '{3'b001, 3'b101, 3'b111, 3'b010, 3'b100, 3'b000, 3'b000};
        logic [31:0] a_t  [7] = '{32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h3, 32'h1, 32'h7, 32'h0};
        logic [31:0] b_t  [7] = '{32'h5, 32'h1, 32'h1, 32'h3, 32'hFFFF_FFFF, 32'h7, 32'h9};
        logic        e_t  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            bus.opcode = op_t[i]; bus.func3 = f3_t[i]; bus.rs1v = a_t[i]; bus.rs2v = b_t[i];
            bus.branch_eval = 1'b1;
            tick();
            idle();
            checks++;
            if (bus.taken !== e_t[i]) begin
                errors++; $display("FAIL decision%0d: got %b want %b", i, bus.taken, e_t[i]);
            end
            $display("decision%0d: op=%b f3=%b taken=%b", i, op_t[i], f3_t[i], bus.taken);
        end
        checks++;
        if (bus.pc !== 32'h44) begin errors++; $display("FAIL decision_pc_hold: got %h want 44", bus.pc); end
    endtask

    task automatic test_jalr_trap;
        // taken is 1 from the JAL decision above; re-evaluate as JALR
        bus.opcode = 7'b1100111; bus.target = 32'h123;
        bus.branch_eval = 1'b1;
        tick();
        idle();
        bus.pc_update = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.misaligned !== 1'b1 || bus.halted !== 1'b1 || bus.pc !== 32'h44 || bus.taken !== 1'b0) begin
            errors++; $display("FAIL jalr_trap: got mis=%b halt=%b pc=%h taken=%b want 1/1/44/0",
                               bus.misaligned, bus.halted, bus.pc, bus.taken);
        end
        $display("jalr trap: pc=%h misaligned=%b", bus.pc, bus.misaligned);
        bus.pc_update = 1'b1; bus.branch_eval = 1'b1;
        tick();
        tick();
        idle();
        checks++;
        if (bus.pc !== 32'h44 || bus.pc_old !== 32'h40 || bus.taken !== 1'b0 || bus.halted !== 1'b1) begin
            errors++; $display("FAIL trap_hold: got pc=%h old=%h taken=%b halt=%b want 44/40/0/1",
                               bus.pc, bus.pc_old, bus.taken, bus.halted);
        end
        bus.trap_clear = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.pc !== 32'h100 || bus.pc_old !== 32'h44 || bus.misaligned !== 1'b0 || bus.halted !== 1'b0) begin
            errors++; $display("FAIL trap_clear: got pc=%h old=%h mis=%b halt=%b want 100/44/0/0",
                               bus.pc, bus.pc_old, bus.misaligned, bus.halted);
        end
        $display("trap clear: pc=%h pc_old=%h", bus.pc, bus.pc_old);
    endtask

    task automatic test_jalr_lsb;
        bus.opcode = 7'b1100111; bus.target = 32'h81;
        bus.branch_eval = 1'b1;
        tick();
        idle();
        bus.pc_update = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.pc !== 32'h80 || bus.misaligned !== 1'b0 || bus.pc_old !== 32'h100) begin
            errors++; $display("FAIL jalr_lsb: got pc=%h old=%h mis=%b want 80/100/0", bus.pc, bus.pc_old, bus.misaligned);
        end
        $display("jalr lsb: pc=%h", bus.pc);
        // 0x82 traps at IALIGN=32 but is a legal target at IALIGN=16
        bus.target = 32'h82; bus16.opcode = 7'b1100111; bus16.target = 32'h82;
        bus.branch_eval = 1'b1; bus16.branch_eval = 1'b1;
        tick();
        idle(); bus16.branch_eval = 1'b0;
        bus.pc_update = 1'b1; bus16.pc_update = 1'b1;
        tick();
        idle(); bus16.pc_update = 1'b0;
        checks++;
        if (bus16.pc !== 32'h82 || bus16.misaligned !== 1'b0 || bus16.pc_old !== 32'h0) begin
            errors++; $display("FAIL ialign16: got pc=%h old=%h mis=%b want 82/0/0", bus16.pc, bus16.pc_old, bus16.misaligned);
        end
        checks++;
        if (bus.misaligned !== 1'b1 || bus.pc !== 32'h80) begin
            errors++; $display("FAIL ialign32_bit1: got mis=%b pc=%h want 1/80", bus.misaligned, bus.pc);
        end
        $display("ialign: pc16=%h pc32=%h mis32=%b", bus16.pc, bus.pc, bus.misaligned);
        bus.trap_clear = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_wrap;
        bus.opcode = 7'b1101111; bus.target = 32'hFFFF_FFFC;
        bus.branch_eval = 1'b1;
        tick();
        idle();
        bus.pc_update = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.pc !== 32'hFFFF_FFFC || bus.pc_plus4 !== 32'h0) begin
            errors++; $display("FAIL jal_top: got pc=%h plus4=%h want fffffffc/0", bus.pc, bus.pc_plus4);
        end
        bus.opcode = 7'b0010011;
        bus.pc_update = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.pc !== 32'h0 || bus.pc_old !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap: got pc=%h old=%h want 0/fffffffc", bus.pc, bus.pc_old);
        end
        $display("wrap: pc=%h pc_old=%h", bus.pc, bus.pc_old);
    endtask

    task automatic test_back_to_back;
        bus.opcode = 7'b1100011; bus.func3 = 3'b000;
        bus.rs1v = 32'h5; bus.rs2v = 32'h5; bus.target = 32'h200;
        bus.branch_eval = 1'b1; bus.pc_update = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.pc !== 32'h4 || bus.taken !== 1'b1) begin
            errors++; $display("FAIL b2b_same_cycle: got pc=%h taken=%b want 4/1", bus.pc, bus.taken);
        end
        bus.pc_update = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.pc !== 32'h200 || bus.pc_old !== 32'h4 || bus.taken !== 1'b0) begin
            errors++; $display("FAIL b2b_follow: got pc=%h old=%h taken=%b want 200/4/0", bus.pc, bus.pc_old, bus.taken);
        end
        $display("back-to-back: pc=%h taken=%b", bus.pc, bus.taken);
    endtask

    task automatic test_reset_in_trap;
        bus.opcode = 7'b1100111; bus.target = 32'h6;
        bus.branch_eval = 1'b1;
        tick();
        idle();
        bus.pc_update = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.halted !== 1'b1) begin errors++; $display("FAIL trap_entry: got halt=%b want 1", bus.halted); end
        rst_n = 1'b0; bus.trap_clear = 1'b1;
        tick();
        rst_n = 1'b1; idle();
        checks++;
        if (bus.pc !== 32'h0 || bus.pc_old !== 32'h0 ||
            {bus.taken, bus.misaligned, bus.halted} !== 3'b000) begin
            errors++; $display("FAIL reset_in_trap: got pc=%h old=%h flags=%b want 0/0/000",
                               bus.pc, bus.pc_old, {bus.taken, bus.misaligned, bus.halted});
        end
        $display("reset in trap: pc=%h halted=%b", bus.pc, bus.halted);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle();
        bus.opcode = '0; bus.func3 = '0; bus.rs1v = '0; bus.rs2v = '0; bus.target = '0;
        bus16.branch_eval = 1'b0; bus16.pc_update = 1'b0; bus16.trap_clear = 1'b0;
        bus16.opcode = '0; bus16.func3 = '0; bus16.rs1v = '0; bus16.rs2v = '0; bus16.target = '0;
        test_reset();
        test_sequential();
        test_signed_branch();
        test_decisions();
        test_jalr_trap();
        test_jalr_lsb();
        test_wrap();
        test_back_to_back();
        test_reset_in_trap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
